// File: rtl/instr_mem_responder.sv
// Instruction memory responder: serves one fetch at a time from a loadable word array.
// Latency: in-range fetch valid WAIT_CYCLES+1 edges after acceptance; out-of-range fetch valid on the accept edge.
// Backpressure: response held stable until rsp_ready; req_ready only in IDLE, so no overlap between fetches.
module instr_mem_responder #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic [31:0]              rsp_addr,
  output logic                     rsp_end,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic                     busy,
  output logic [15:0]              fetch_count
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_wait_cnt;
  logic [31:0] r_rsp_data;
  logic [31:0] r_rsp_addr;
  logic        r_rsp_end;
  logic [15:0] r_fetch_count;
  logic [31:0] r_mem [DEPTH];

  logic        w_in_range;
  logic        w_accept;
  logic        w_sample;
  logic        w_release;
  logic [AW-1:0] w_rd_idx;

  // Full 32-bit unsigned compare so large indices never alias into the array.
  assign w_in_range = (req_addr < 32'(DEPTH));
  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_sample   = (r_state == READ) && (r_wait_cnt == 3'd0);
  assign w_release  = (r_state == RESP) && rsp_ready;
  assign w_rd_idx   = r_rsp_addr[AW-1:0];

  assign req_ready   = (r_state == IDLE);
  assign rsp_valid   = (r_state == RESP);
  assign busy        = (r_state != IDLE);
  assign rsp_data    = r_rsp_data;
  assign rsp_addr    = r_rsp_addr;
  assign rsp_end     = r_rsp_end;
  assign fetch_count = r_fetch_count;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: in-range fetches wait in READ, out-of-range ones skip straight to RESP.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_nxt = w_in_range ? READ : RESP;
        end
      end
      READ: begin
        if (r_wait_cnt == 3'd0) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Wait-state counter: loaded on an in-range accept, counts down while in READ.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= 3'd0;
    end else if (w_accept) begin
      r_wait_cnt <= w_in_range ? WAIT_INIT : 3'd0;
    end else if ((r_state == READ) && (r_wait_cnt != 3'd0)) begin
      r_wait_cnt <= r_wait_cnt - 3'd1;
    end
  end

  // Response address and end flag are captured at acceptance and held until the next accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_addr <= 32'd0;
      r_rsp_end  <= 1'b0;
    end else if (w_accept) begin
      r_rsp_addr <= req_addr;
      r_rsp_end  <= !w_in_range;
    end
  end

  // Response word: cleared on accept (the out-of-range answer), filled from memory on the last READ cycle.
  // The non-blocking read sees the pre-write word if a load hits the same index on this edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_data <= 32'd0;
    end else if (w_accept) begin
      r_rsp_data <= 32'd0;
    end else if (w_sample) begin
      r_rsp_data <= r_mem[w_rd_idx];
    end
  end

  // Completed-response counter, saturating at all ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_count <= 16'd0;
    end else if (w_release && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  // Program storage: written in any state, deliberately untouched by reset.
  always_ff @(posedge clock) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

endmodule
